// File: rtl/even_parity_checker_serial.sv
// Serial even-parity frame receiver: DATA_W data bits LSB first plus one parity bit,
// with inter-bit idle timeout and a saturating parity-error counter.
module even_parity_checker_serial #(
   parameter int unsigned DATA_W  = 3,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              frame_valid,
   output logic              parity_err,
   output logic              frame_abort,
   output logic [7:0]        err_count
);

   localparam int unsigned CNT_W     = $clog2(DATA_W + 1);
   localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        idle_q, idle_d;
   logic              xor_q, xor_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              perr_q, perr_d;
   logic              fv_q, fv_d;
   logic              abort_q, abort_d;
   logic [7:0]        errc_q, errc_d;
   logic [DATA_W-1:0] shift_in;
   logic              frame_bad;

   // Bits enter at the MSB and shift down, so after DATA_W bits the first one sits at bit 0.
   assign shift_in  = (shift_q >> 1) | (DATA_W'(bit_in) << (DATA_W - 1));
   assign frame_bad = xor_q ^ bit_in;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      xor_d   = xor_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      perr_d  = perr_q;
      fv_d    = 1'b0;
      abort_d = 1'b0;
      errc_d  = errc_q;
      case (state_q)
         IDLE: begin
            if (bit_valid) begin
               shift_d = shift_in;
               xor_d   = bit_in;
               cnt_d   = CNT_W'(1);
               idle_d  = '0;
               state_d = (DATA_W == 1) ? PARITY : DATA;
            end
         end
         DATA, PARITY: begin
            if (bit_valid) begin
               idle_d = '0;
               if (state_q == DATA) begin
                  shift_d = shift_in;
                  xor_d   = xor_q ^ bit_in;
                  cnt_d   = cnt_q + CNT_W'(1);
                  if (cnt_q + CNT_W'(1) == CNT_W'(DATA_W)) state_d = PARITY;
               end else begin
                  dout_d  = shift_q;
                  perr_d  = frame_bad;
                  fv_d    = 1'b1;
                  state_d = IDLE;
                  if (frame_bad && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
               end
            end else if (idle_q + 8'd1 == TIMEOUT_C) begin
               state_d = IDLE;
               idle_d  = '0;
               abort_d = 1'b1;
            end else begin
               idle_d = idle_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idle_q  <= '0;
         xor_q   <= 1'b0;
         shift_q <= '0;
         dout_q  <= '0;
         perr_q  <= 1'b0;
         fv_q    <= 1'b0;
         abort_q <= 1'b0;
         errc_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         xor_q   <= xor_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         perr_q  <= perr_d;
         fv_q    <= fv_d;
         abort_q <= abort_d;
         errc_q  <= errc_d;
      end
   end

   assign data_out    = dout_q;
   assign parity_err  = perr_q;
   assign frame_valid = fv_q;
   assign frame_abort = abort_q;
   assign err_count   = errc_q;

endmodule

// File: doc/even_parity_checker_serial.md
EVEN_PARITY_CHECKER_SERIAL -- requirements
Module: even_parity_checker_serial

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter DATA_W, default 3: number of data bits per frame, legal range 1..16.
REQ-003 Parameter TIMEOUT, default 15: maximum idle cycles allowed between bits inside a frame, legal range 1..255.
REQ-004 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port bit_in, input, 1 bit: serial frame bit, sampled only when bit_valid=1.
REQ-007 Port bit_valid, input, 1 bit: bit_in carries a valid bit this cycle.
REQ-008 Port data_out, output, DATA_W bits: last received data word, registered.
REQ-009 Port frame_valid, output, 1 bit: one-cycle pulse marking a completed frame.
REQ-010 Port parity_err, output, 1 bit: with frame_valid, 1 when the frame fails the even-parity check.
REQ-011 Port frame_abort, output, 1 bit: one-cycle pulse when an incomplete frame is discarded by timeout.
REQ-012 Port err_count, output, 8 bits: saturating count of frames with parity_err=1.

Function
REQ-013 Each frame SHALL be DATA_W data bits sent LSB first, followed by one even-parity bit; the parity bit equals the XOR of the data bits.
REQ-014 The FSM SHALL have three states: IDLE, DATA and PARITY.
REQ-015 In IDLE, a cycle with bit_valid=1 SHALL store bit_in as data bit 0, load the running XOR with bit_in, and go to DATA; if DATA_W=1 it SHALL go directly to PARITY.
REQ-016 In DATA, each bit_valid=1 cycle SHALL store the next data bit and XOR it into the running parity; after bit DATA_W-1 is accepted the FSM SHALL go to PARITY.
REQ-017 In PARITY, a bit_valid=1 cycle SHALL end the frame and return the FSM to IDLE.
REQ-018 At the clock edge that accepts the parity bit, data_out SHALL load the assembled word, parity_err SHALL load (running XOR ^ bit_in), and frame_valid SHALL be 1 for exactly the following cycle; latency from parity bit to frame_valid is one cycle.
REQ-019 data_out and parity_err SHALL hold their values until the next completed frame.
REQ-020 A bit_valid=1 in the cycle frame_valid is high SHALL be accepted as bit 0 of a new frame; back-to-back frames need no gap.
REQ-021 An idle counter SHALL clear on every accepted bit and increment on each bit_valid=0 cycle in DATA or PARITY.
REQ-022 When the idle counter reaches TIMEOUT, the FSM SHALL go to IDLE, discard the partial frame, leave data_out, parity_err and err_count unchanged, and pulse frame_abort for one cycle.
REQ-023 If a bit arrives in the same cycle the counter would reach TIMEOUT, the bit SHALL be accepted and no abort SHALL occur.
REQ-024 err_count SHALL increment by 1 on each frame completed with parity_err=1 and SHALL saturate at 255 without wrapping.
REQ-025 bit_valid=0 in IDLE SHALL cause no state change; bit_in SHALL be ignored whenever bit_valid=0.

Reset
REQ-026 rst=1 SHALL immediately force the FSM to IDLE and clear the idle counter, the running XOR, data_out=0, parity_err=0, frame_valid=0, frame_abort=0 and err_count=0.
REQ-027 Reset asserted in the middle of a frame SHALL discard the partial frame without a frame_valid or frame_abort pulse.
REQ-028 The first bit_valid=1 after rst is released SHALL be treated as data bit 0.

Verification (DATA_W=3, TIMEOUT=15)
REQ-029 Good frame: send bits 1,0,1 then parity 0 on consecutive cycles -> one cycle later frame_valid=1, data_out=3'b101, parity_err=0, err_count=0.
REQ-030 Bad frame: send bits 1,1,0 then parity 1 -> frame_valid=1, data_out=3'b011, parity_err=1, err_count=1.
REQ-031 Back-to-back and exhaustive: all 8 data words sent with correct parity and no gaps -> 8 frame_valid pulses, every parity_err=0, data_out matching each word.
REQ-032 Timeout: send bits 1,0, then hold bit_valid=0 for 15 cycles -> frame_abort pulses once and there is no frame_valid; a following frame 0,0,1 with parity 1 -> data_out=3'b100, parity_err=0.
REQ-033 Gaps: the same good frame with 14 idle cycles between each bit -> no abort, and frame_valid with data_out=3'b101.
REQ-034 Saturation and reset: send 260 bad frames -> err_count=255; assert rst after bit 2 of the next frame -> all outputs become 0 at once with no pulse.
